// File: rtl/styler_pkg.sv
// Shared types and constants for the character-cell styler and its sequencer.
package styler_pkg;

  localparam int ATTR_W = 25;
  localparam int CTRL_W = 6;
  localparam int ROWS   = 16;
  localparam int ROW_W  = 4;
  localparam int DATA_W = 16;

  localparam int ATTR_BLINK  = 12;
  localparam int ATTR_HIDDEN = 15;

  // Bit positions inside the ctrl word {blinkEn,lineEn,cursorEn,cursorBlink,cursorTop,cursorBottom}
  localparam int CTRL_BLINK_EN      = 5;
  localparam int CTRL_LINE_EN       = 4;
  localparam int CTRL_CURSOR_EN     = 3;
  localparam int CTRL_CURSOR_BLINK  = 2;
  localparam int CTRL_CURSOR_TOP    = 1;
  localparam int CTRL_CURSOR_BOTTOM = 0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    STYLE = 2'd2,
    OUT   = 2'd3
  } seq_state_t;

  function automatic logic is_last_row(input logic [ROW_W-1:0] row);
    return row == ROW_W'(ROWS - 1);
  endfunction

endpackage

// File: rtl/styler_cell_sequencer_if.sv
// Bus bundle for the cell sequencer: cell request, font row fetch and styled-row stream.
interface styler_cell_sequencer_if
  import styler_pkg::*;
#(
  parameter int GLYPH_W = 8
);

  logic                 cell_valid;
  logic                 cell_ready;
  logic [GLYPH_W-1:0]   cell_glyph;
  logic [ATTR_W-1:0]    cell_attr;
  logic [CTRL_W-1:0]    cell_ctrl;

  logic                 font_req;
  logic [GLYPH_W+3:0]   font_addr;
  logic                 font_ack;
  logic [DATA_W-1:0]    font_data;

  logic                 row_valid;
  logic                 row_ready;
  logic [DATA_W-1:0]    row_data;
  logic [ROW_W-1:0]     row_index;
  logic                 row_last;

  // master: the environment feeding cells, serving font rows and sinking styled rows
  modport master (
    output cell_valid, cell_glyph, cell_attr, cell_ctrl,
    output font_ack, font_data,
    output row_ready,
    input  cell_ready, font_req, font_addr,
    input  row_valid, row_data, row_index, row_last
  );

  modport slave (
    input  cell_valid, cell_glyph, cell_attr, cell_ctrl,
    input  font_ack, font_data,
    input  row_ready,
    output cell_ready, font_req, font_addr,
    output row_valid, row_data, row_index, row_last
  );

endinterface

// File: rtl/styler_cell_sequencer_phase_gen.sv
// Frame-rate phase generators: faint toggles every frame_tick, blink/cursor toggle every DIV ticks.
module styler_phase_gen #(
  parameter int BLINK_DIV  = 32,
  parameter int CURSOR_DIV = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic frame_tick,
  output logic faint_phase,
  output logic blink_phase,
  output logic cursor_phase
);

  localparam int BLINK_W  = (BLINK_DIV  > 2) ? $clog2(BLINK_DIV)  : 1;
  localparam int CURSOR_W = (CURSOR_DIV > 2) ? $clog2(CURSOR_DIV) : 1;

  logic [BLINK_W-1:0]  blink_cnt;
  logic [CURSOR_W-1:0] cursor_cnt;

  // Counters advance only on frame_tick; a phase flips on the tick that wraps its counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      faint_phase  <= 1'b0;
      blink_phase  <= 1'b0;
      cursor_phase <= 1'b0;
      blink_cnt    <= '0;
      cursor_cnt   <= '0;
    end else if (frame_tick) begin
      faint_phase <= ~faint_phase;

      if (blink_cnt == BLINK_W'(BLINK_DIV - 1)) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt <= blink_cnt + BLINK_W'(1);
      end

      if (cursor_cnt == CURSOR_W'(CURSOR_DIV - 1)) begin
        cursor_cnt   <= '0;
        cursor_phase <= ~cursor_phase;
      end else begin
        cursor_cnt <= cursor_cnt + CURSOR_W'(1);
      end
    end
  end

endmodule

// File: rtl/styler_cell_sequencer.sv
// Walks one character cell through the external styler, 16 scanlines, one font fetch per row.
// Optional macro STYLER_SEQ_PHASE_LOCK_EN freezes the phase outputs for the duration of a cell.
module styler_cell_sequencer
  import styler_pkg::*;
#(
  parameter int GLYPH_W    = 8,
  parameter int BLINK_DIV  = 32,
  parameter int CURSOR_DIV = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  frame_tick,
  styler_cell_sequencer_if.slave bus,
  output logic [ROW_W-1:0]      sty_scanline,
  output logic [DATA_W-1:0]     sty_bitmap,
  output logic [ATTR_W-1:0]     sty_attr,
  output logic [CTRL_W-1:0]     sty_ctrl,
  input  logic [ROW_W-1:0]      sty_scanline_out,
  input  logic [DATA_W-1:0]     sty_bitmap_out,
  output logic                  faint_phase,
  output logic                  blink_phase,
  output logic                  cursor_phase,
  output logic                  busy
);

  seq_state_t          state;
  seq_state_t          state_nxt;

  logic [GLYPH_W-1:0]  glyph_q;
  logic [ROW_W-1:0]    row_q;
  logic [DATA_W-1:0]   row_data_q;
  logic [ROW_W-1:0]    row_index_q;

  logic                accept;
  logic                fetch_done;
  logic                row_done;

  logic                gen_faint;
  logic                gen_blink;
  logic                gen_cursor;

  styler_phase_gen #(
    .BLINK_DIV  (BLINK_DIV),
    .CURSOR_DIV (CURSOR_DIV)
  ) u_phase_gen (
    .clk          (clk),
    .rst_n        (rst_n),
    .frame_tick   (frame_tick),
    .faint_phase  (gen_faint),
    .blink_phase  (gen_blink),
    .cursor_phase (gen_cursor)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    accept     = 1'b0;
    fetch_done = 1'b0;
    row_done   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.cell_valid) begin
          accept    = 1'b1;
          state_nxt = FETCH;
        end
      end
      FETCH: begin
        if (bus.font_ack) begin
          fetch_done = 1'b1;
          state_nxt  = STYLE;
        end
      end
      STYLE: begin
        state_nxt = OUT;
      end
      OUT: begin
        if (bus.row_ready) begin
          row_done  = 1'b1;
          state_nxt = is_last_row(row_q) ? IDLE : FETCH;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Cell context is latched once on accept; the styler sees it unchanged for all 16 rows.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      glyph_q     <= '0;
      sty_attr    <= '0;
      sty_ctrl    <= '0;
      row_q       <= '0;
      sty_bitmap  <= '0;
      row_data_q  <= '0;
      row_index_q <= '0;
    end else begin
      if (accept) begin
        glyph_q  <= bus.cell_glyph;
        sty_attr <= bus.cell_attr;
        sty_ctrl <= bus.cell_ctrl;
        row_q    <= '0;
      end
      if (fetch_done) begin
        sty_bitmap <= bus.font_data;
      end
      if (state == STYLE) begin
        row_data_q  <= sty_bitmap_out;
        row_index_q <= row_q;
      end
      if (row_done && !is_last_row(row_q)) begin
        row_q <= row_q + ROW_W'(1);
      end
    end
  end

  assign busy           = (state != IDLE);
  assign sty_scanline   = row_q;

  assign bus.cell_ready = (state == IDLE);
  assign bus.font_req   = (state == FETCH);
  assign bus.font_addr  = (state == FETCH) ? {glyph_q, sty_scanline_out} : '0;
  assign bus.row_valid  = (state == OUT);
  assign bus.row_data   = row_data_q;
  assign bus.row_index  = row_index_q;
  assign bus.row_last   = is_last_row(row_index_q);

`ifdef STYLER_SEQ_PHASE_LOCK_EN
  logic lock_faint;
  logic lock_blink;
  logic lock_cursor;

  // Snapshot taken on the accepting edge so every row of the cell uses the same phases.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_faint  <= 1'b0;
      lock_blink  <= 1'b0;
      lock_cursor <= 1'b0;
    end else if (accept) begin
      lock_faint  <= gen_faint;
      lock_blink  <= gen_blink;
      lock_cursor <= gen_cursor;
    end
  end

  assign faint_phase  = busy ? lock_faint  : gen_faint;
  assign blink_phase  = busy ? lock_blink  : gen_blink;
  assign cursor_phase = busy ? lock_cursor : gen_cursor;
`else
  assign faint_phase  = gen_faint;
  assign blink_phase  = gen_blink;
  assign cursor_phase = gen_cursor;
`endif

endmodule

// File: tb/tb_styler_cell_sequencer.sv
// Directed bench for styler_cell_sequencer with an identity-scanline, inverting-bitmap styler model.
module tb_styler_cell_sequencer;
  import styler_pkg::*;

  localparam int GLYPH_W = 8;

  typedef struct {
    logic [7:0]  glyph;
    logic [24:0] attr;
    logic [5:0]  ctrl;
    logic [11:0] exp_addr0;
    logic [15:0] exp_data0;
    int          exp_cycles;
  } cell_vec_t;

  typedef struct packed {
    logic [3:0]  idx;
    logic [15:0] data;
    logic        last;
    logic        blink;
  } row_rec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        frame_tick = 1'b0;
  logic [3:0]  sty_scanline;
  logic [15:0] sty_bitmap;
  logic [24:0] sty_attr;
  logic [5:0]  sty_ctrl;
  logic [3:0]  sty_scanline_out;
  logic [15:0] sty_bitmap_out;
  logic        faint_phase, blink_phase, cursor_phase, busy;

  int checks = 0;
  int errors = 0;

  logic        delay_en = 1'b0;
  logic [3:0]  ack_row = 4'd3;
  int          ack_wait_len = 0;
  int          req_cnt;
  logic        ack_hold;

  logic        stall_en = 1'b0;
  logic [3:0]  stall_row = 4'd7;
  int          stall_len = 0;
  int          stall_cnt;
  logic        stall_hold;

  logic        mon_clear = 1'b0;
  logic [7:0]  cur_glyph = 8'h00;
  row_rec_t    row_q[$];
  logic [11:0] fetch_q[$];
  int          req_total, req3_cnt, addr_bad, held_cnt, held_bad;
  logic        prev_req;
  logic [11:0] prev_addr;

  always #5 clk = ~clk;

  styler_cell_sequencer_if #(.GLYPH_W(GLYPH_W)) bus ();

  styler_cell_sequencer #(
    .GLYPH_W    (GLYPH_W),
    .BLINK_DIV  (32),
    .CURSOR_DIV (16)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .frame_tick       (frame_tick),
    .bus              (bus.slave),
    .sty_scanline     (sty_scanline),
    .sty_bitmap       (sty_bitmap),
    .sty_attr         (sty_attr),
    .sty_ctrl         (sty_ctrl),
    .sty_scanline_out (sty_scanline_out),
    .sty_bitmap_out   (sty_bitmap_out),
    .faint_phase      (faint_phase),
    .blink_phase      (blink_phase),
    .cursor_phase     (cursor_phase),
    .busy             (busy)
  );

  function automatic logic [15:0] font_rom(input logic [11:0] a);
    return {a[3:0], a} ^ 16'h5A5A;
  endfunction

  function automatic logic [15:0] exp_row(input logic [7:0] g, input logic [3:0] r);
    logic [11:0] a;
    a = {g, r};
    return ~font_rom(a);
  endfunction

  // Styler stand-in: scanline passes through, bitmap is inverted so capture of the styled value is visible.
  assign sty_scanline_out = sty_scanline;
  assign sty_bitmap_out   = ~sty_bitmap;

  assign bus.font_data = font_rom(bus.font_addr);
  assign ack_hold      = delay_en && (bus.font_addr[3:0] == ack_row) && (req_cnt < ack_wait_len);
  assign bus.font_ack  = bus.font_req && !ack_hold;
  assign stall_hold    = stall_en && bus.row_valid && (bus.row_index == stall_row) && (stall_cnt < stall_len);
  assign bus.row_ready = !stall_hold;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_cnt   <= 0;
      stall_cnt <= 0;
    end else begin
      req_cnt   <= (bus.font_req && !bus.font_ack) ? req_cnt + 1 : 0;
      stall_cnt <= stall_hold ? stall_cnt + 1 : 0;
    end
  end

  // Observes the bus half a cycle away from the active edge.
  always @(negedge clk) begin
    if (mon_clear) begin
      row_q.delete();
      fetch_q.delete();
      req_total = 0; req3_cnt = 0; addr_bad = 0; held_cnt = 0; held_bad = 0;
      prev_req  = 1'b0;
      prev_addr = '0;
    end else if (rst_n) begin
      if (bus.row_valid && bus.row_ready)
        row_q.push_back('{bus.row_index, bus.row_data, bus.row_last, blink_phase});
      if (bus.row_valid && !bus.row_ready) begin
        held_cnt++;
        if (bus.row_index != stall_row || bus.row_data != exp_row(cur_glyph, stall_row)) held_bad++;
      end
      if (bus.font_req) begin
        req_total++;
        if (bus.font_addr[3:0] == 4'd3) req3_cnt++;
        if (prev_req && bus.font_addr != prev_addr) addr_bad++;
        if (bus.font_ack) fetch_q.push_back(bus.font_addr);
      end
      prev_req  = bus.font_req && !bus.font_ack;
      prev_addr = bus.font_addr;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [7:0] g, input logic [24:0] a, input logic [5:0] c);
    bus.cell_valid = v;
    bus.cell_glyph = g;
    bus.cell_attr  = a;
    bus.cell_ctrl  = c;
  endtask

  task automatic clearMonitor();
    mon_clear = 1'b1;
    @(negedge clk);
    #1 mon_clear = 1'b0;
  endtask

  task automatic startCell(input logic [7:0] g, input logic [24:0] a, input logic [5:0] c);
    int guard;
    guard = 0;
    clearMonitor();
    cur_glyph = g;
    while (!bus.cell_ready && guard < 500) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 500) checkOutput("ready_timeout", 32'd1, 32'd0);
    applyStimulus(1'b1, g, a, c);
    @(posedge clk); #1;
    bus.cell_valid = 1'b0;
  endtask

  task automatic runCell(input logic [7:0] g, input logic [24:0] a, input logic [5:0] c, output int cycles);
    startCell(g, a, c);
    cycles = 0;
    while (busy && cycles < 2000) begin
      @(posedge clk); #1;
      cycles++;
    end
    if (cycles == 0) cycles = -1;
    if (busy) checkOutput("cell_timeout", 32'd1, 32'd0);
  endtask

  task automatic checkRows(input logic [7:0] g);
    checkOutput("row_count", 32'(row_q.size()), 32'd16);
    checkOutput("fetch_count", 32'(fetch_q.size()), 32'd16);
    for (int i = 0; i < 16 && i < row_q.size(); i++) begin
      checkOutput($sformatf("row%0d_index", i), 32'(row_q[i].idx), 32'(i));
      checkOutput($sformatf("row%0d_last", i), 32'(row_q[i].last), 32'(i == 15));
      checkOutput($sformatf("row%0d_data", i), 32'(row_q[i].data), 32'(exp_row(g, 4'(i))));
    end
    for (int i = 0; i < 16 && i < fetch_q.size(); i++)
      checkOutput($sformatf("row%0d_addr", i), 32'(fetch_q[i]), 32'({g, 4'(i)}));
  endtask

  task automatic tickOnce();
    @(posedge clk); #1 frame_tick = 1'b1;
    @(posedge clk); #1 frame_tick = 1'b0;
  endtask

  initial begin
    cell_vec_t vecs[4];
    int        cycles;
    int        faint_t, blink_t, cursor_t;
    int        guard;
    logic      pf, pb, pc;

    vecs[0] = '{8'h41, 25'h0001000, 6'b100000, 12'h410, 16'hA1B5, 48};
    vecs[1] = '{8'h00, 25'h1FFFFFF, 6'b111111, 12'h000, 16'hA5A5, 48};
    vecs[2] = '{8'hFF, 25'h0008000, 6'b001000, 12'hFF0, 16'hAA55, 48};
    vecs[3] = '{8'h7E, 25'h0000000, 6'b000000, 12'h7E0, 16'hA245, 48};

    applyStimulus(1'b0, 8'h00, 25'h0, 6'h0);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_cell_ready", 32'(bus.cell_ready), 32'd1);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_row_valid", 32'(bus.row_valid), 32'd0);
    checkOutput("rst_font_req", 32'(bus.font_req), 32'd0);
    checkOutput("rst_font_addr", 32'(bus.font_addr), 32'd0);
    checkOutput("rst_row_data", 32'(bus.row_data), 32'd0);
    checkOutput("rst_phases", 32'({faint_phase, blink_phase, cursor_phase}), 32'd0);
    checkOutput("rst_sty_attr", 32'(sty_attr), 32'd0);
    checkOutput("rst_sty_ctrl", 32'(sty_ctrl), 32'd0);
    rst_n = 1'b1;

    $display("[TB] table-driven cells");
    for (int v = 0; v < 4; v++) begin
      runCell(vecs[v].glyph, vecs[v].attr, vecs[v].ctrl, cycles);
      checkOutput($sformatf("vec%0d_cycles", v), 32'(cycles), 32'(vecs[v].exp_cycles));
      checkOutput($sformatf("vec%0d_addr0", v), 32'(fetch_q.size() > 0 ? fetch_q[0] : 12'hBAD), 32'(vecs[v].exp_addr0));
      checkOutput($sformatf("vec%0d_data0", v), 32'(row_q.size() > 0 ? row_q[0].data : 16'h0BAD), 32'(vecs[v].exp_data0));
      checkOutput($sformatf("vec%0d_sty_attr", v), 32'(sty_attr), 32'(vecs[v].attr));
      checkOutput($sformatf("vec%0d_sty_ctrl", v), 32'(sty_ctrl), 32'(vecs[v].ctrl));
      checkRows(vecs[v].glyph);
    end

    $display("[TB] delayed font_ack on row 3");
    delay_en = 1'b1; ack_row = 4'd3; ack_wait_len = 5;
    runCell(8'h41, 25'h0, 6'h0, cycles);
    delay_en = 1'b0;
    checkOutput("delay_cycles", 32'(cycles), 32'd53);
    checkOutput("delay_req3_cycles", 32'(req3_cnt), 32'd6);
    checkOutput("delay_addr_stable", 32'(addr_bad), 32'd0);
    checkRows(8'h41);

    $display("[TB] row_ready stall on row 7");
    stall_en = 1'b1; stall_row = 4'd7; stall_len = 10;
    runCell(8'h52, 25'h0, 6'h0, cycles);
    stall_en = 1'b0;
    checkOutput("stall_cycles", 32'(cycles), 32'd58);
    checkOutput("stall_held_cycles", 32'(held_cnt), 32'd10);
    checkOutput("stall_held_bad", 32'(held_bad), 32'd0);
    checkOutput("stall_req_total", 32'(req_total), 32'd16);
    checkRows(8'h52);

    $display("[TB] phase generators over 40 ticks");
    faint_t = 0; blink_t = 0; cursor_t = 0;
    for (int t = 0; t < 40; t++) begin
      pf = faint_phase; pb = blink_phase; pc = cursor_phase;
      tickOnce();
      if (faint_phase != pf) faint_t++;
      if (blink_phase != pb) blink_t++;
      if (cursor_phase != pc) cursor_t++;
    end
    checkOutput("faint_toggles", 32'(faint_t), 32'd40);
    checkOutput("blink_toggles", 32'(blink_t), 32'd1);
    checkOutput("cursor_toggles", 32'(cursor_t), 32'd2);
    checkOutput("phases_after_40", 32'({faint_phase, blink_phase, cursor_phase}), 32'b010);

    // Blink counter now sits at 8; 23 more ticks park it at 31 so the next tick wraps.
    repeat (23) tickOnce();
    checkOutput("blink_before_wrap", 32'(blink_phase), 32'd1);

    $display("[TB] blink wrap mid-cell");
    fork
      runCell(8'h21, 25'h0001000, 6'b100000, cycles);
      begin
        guard = 0;
        while (!(bus.row_valid && bus.row_index == 4'd5) && guard < 500) begin
          @(posedge clk); #1;
          guard++;
        end
        frame_tick = 1'b1;
        @(posedge clk); #1 frame_tick = 1'b0;
      end
    join
    checkOutput("lock_cell_cycles", 32'(cycles), 32'd48);
    checkOutput("lock_row_count", 32'(row_q.size()), 32'd16);
    for (int i = 0; i < 16 && i < row_q.size(); i++) begin
`ifdef STYLER_SEQ_PHASE_LOCK_EN
      checkOutput($sformatf("row%0d_blink", i), 32'(row_q[i].blink), 32'd1);
`else
      checkOutput($sformatf("row%0d_blink", i), 32'(row_q[i].blink), 32'(i <= 5));
`endif
    end
    checkOutput("blink_after_wrap_idle", 32'(blink_phase), 32'd0);

    $display("[TB] async reset during row 9");
    stall_en = 1'b1; stall_row = 4'd9; stall_len = 1000;
    startCell(8'h30, 25'h0000ABC, 6'b010101);
    guard = 0;
    while (!(bus.row_valid && bus.row_index == 4'd9) && guard < 500) begin
      @(posedge clk); #1;
      guard++;
    end
    checkOutput("reach_row9", 32'(bus.row_valid && bus.row_index == 4'd9), 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("abort_row_valid", 32'(bus.row_valid), 32'd0);
    checkOutput("abort_busy", 32'(busy), 32'd0);
    checkOutput("abort_cell_ready", 32'(bus.cell_ready), 32'd1);
    checkOutput("abort_font_req", 32'(bus.font_req), 32'd0);
    checkOutput("abort_phases", 32'({faint_phase, blink_phase, cursor_phase}), 32'd0);
    checkOutput("abort_sty_attr", 32'(sty_attr), 32'd0);
    checkOutput("abort_rows_emitted", 32'(row_q.size()), 32'd9);
    @(posedge clk); #1;
    stall_en = 1'b0;
    rst_n = 1'b1;
    runCell(8'h30, 25'h0000ABC, 6'b010101, cycles);
    checkOutput("restart_cycles", 32'(cycles), 32'd48);
    checkRows(8'h30);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
